shl_seq: RTL and testbench

Sequential left shifter for the datapath component library, the left-shift counterpart of the combinational right shifter. It accepts an operand and shift amount on a start pulse, shifts one bit position per clock, and returns the registered result with a one-cycle done pulse. Generated datapaths use it where a full combinational barrel shift would break timing. Schedulers sequence it through a start/busy/done handshake.

---
 rtl/shl_seq.sv | 89 ++++++++
 tb/tb_shl_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shl_seq.sv
// shl_seq: sequential logical left shifter.
// Captures an operand and shift amount on an accepted start, shifts the
// working register one position per clock, then publishes the result on d
// with a one-cycle done pulse. All outputs come straight from flops.
module shl_seq #(
    parameter int DATAWIDTH = 16,
    parameter int SHWIDTH   = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [SHWIDTH-1:0]   sh_amt,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] d
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATAWIDTH-1:0] work;
    logic [SHWIDTH-1:0]   cnt;

    // State register; reset aborts any operation in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: IDLE accepts start, SHIFT finishes when cnt hits 0.
    // NOTE: the default assignment first means every path drives state_next,
    // so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = SHIFT;
            SHIFT:   if (cnt == '0)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Output decode: busy is a pure function of the state flop.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Datapath: operand capture, one-bit shift per cycle, result publish.
    // Amounts of DATAWIDTH or more need no special case: the register
    // drains to zero after DATAWIDTH shifts and the count still runs out.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            work <= '0;
            cnt  <= '0;
            d    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= a;
                        cnt  <= sh_amt;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work <= {work[DATAWIDTH-2:0], 1'b0};
                        cnt  <= cnt - 1'b1;
                    end else begin
                        d    <= work;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shl_seq.sv
// Directed self-checking bench for shl_seq. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_shl_seq;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [15:0] a;
    logic [3:0]  sh_amt;
    logic        busy;
    logic        done;
    logic [15:0] d;

    int vectors     = 0;
    int miscompares = 0;

    shl_seq #(.DATAWIDTH(16), .SHWIDTH(4)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .start  (start),
        .a      (a),
        .sh_amt (sh_amt),
        .busy   (busy),
        .done   (done),
        .d      (d)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op and check busy/done/d on every cycle of its latency,
    // plus the cycle after done.
    task automatic run_op(input string tag, input logic [15:0] op_a,
                          input logic [3:0] op_sh, input logic [15:0] exp_d);
        int lat;
        lat = int'(op_sh) + 1;
        start  = 1'b1;
        a      = op_a;
        sh_amt = op_sh;
        @(negedge Clk);                       // after accepting edge E
        start  = 1'b0;
        a      = 16'hDEAD;                    // later input changes must not matter
        sh_amt = 4'hF;
        check({tag, " busy@E"}, busy, 1'b1);
        check({tag, " done@E"}, done, 1'b0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge Clk);
            if (k < lat) begin
                check({tag, " busy mid"}, busy, 1'b1);
                check({tag, " done mid"}, done, 1'b0);
            end else begin
                check({tag, " done"},   done, 1'b1);
                check({tag, " busy end"}, busy, 1'b0);
                check({tag, " d"},      d,    exp_d);
            end
        end
        @(negedge Clk);
        check({tag, " done clr"}, done, 1'b0);
        check({tag, " d hold"},   d,    exp_d);
    endtask

    // Watchdog: the sequence below has no open-ended waits, this is a backstop.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with random inputs and toggling start.
        Rst    = 1'b0;
        start  = 1'b0;
        a      = '0;
        sh_amt = '0;
        for (int i = 0; i < 6; i++) begin
            a      = 16'($urandom);
            sh_amt = 4'($urandom);
            start  = ~start;
            @(negedge Clk);
            check("rst busy", busy, 1'b0);
            check("rst done", done, 1'b0);
            check("rst d",    d,    16'h0000);
        end
        start = 1'b0;
        Rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("post-rst done", done, 1'b0);
            check("post-rst busy", busy, 1'b0);
        end

        // Basic and boundary shifts.
        run_op("basic",  16'h0001, 4'd4,  16'h0010);
        @(negedge Clk);
        check("basic d hold2", d, 16'h0010);
        run_op("sh0",    16'hABCD, 4'd0,  16'hABCD);
        run_op("sh15",   16'h8001, 4'd15, 16'h8000);

        // Busy protection: second start during busy is dropped.
        start = 1'b1; a = 16'h00FF; sh_amt = 4'd8;
        @(negedge Clk);                       // after E
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 16'h1234; sh_amt = 4'd1;
            end else if (k == 4) begin
                a = 16'h5555; sh_amt = 4'd3;
            end else if (k == 5) begin
                start = 1'b0;
            end
            @(negedge Clk);
            if (k < 9) check("prot done mid", done, 1'b0);
        end
        check("prot done", done, 1'b1);
        check("prot d",    d,    16'hFF00);
        @(negedge Clk);
        check("prot busy after", busy, 1'b0);
        @(negedge Clk);
        check("prot no 2nd done", done, 1'b0);
        check("prot d kept",      d,    16'hFF00);

        // Back-to-back with start held high.
        start = 1'b1; a = 16'h0003; sh_amt = 4'd2;
        @(negedge Clk);                       // after E
        check("b2b busy1", busy, 1'b1);
        @(negedge Clk); @(negedge Clk); @(negedge Clk);   // after E+3
        check("b2b done1", done, 1'b1);
        check("b2b d1",    d,    16'h000C);
        a = 16'h0F00; sh_amt = 4'd3;
        @(negedge Clk);                       // after E2 = E+4: no gap
        check("b2b busy2", busy, 1'b1);
        check("b2b done off", done, 1'b0);
        for (int k = 1; k < 4; k++) begin
            @(negedge Clk);
            check("b2b done mid2", done, 1'b0);
        end
        @(negedge Clk);                       // after E2+4
        check("b2b done2", done, 1'b1);
        check("b2b d2",    d,    16'h7800);
        start = 1'b0;

        // Reset in the middle of an operation.
        @(negedge Clk);
        start = 1'b1; a = 16'h0001; sh_amt = 4'd10;
        @(negedge Clk);                       // after E
        start = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge Clk);
        check("mid busy before rst", busy, 1'b1);
        Rst = 1'b0;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst done", done, 1'b0);
        check("mid rst d",    d,    16'h0000);
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            check("mid no done", done, 1'b0);
            check("mid idle",    busy, 1'b0);
        end
        check("mid d zero", d, 16'h0000);
        run_op("fresh", 16'h0002, 4'd1, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
